// File: rtl/bus_arb_if.sv
// Shared-bus bundle: two requesting masters plus the single device port.
// Latency: none (wires only).
// Backpressure: masters hold req until their one-cycle ack; the device port has no stall.
interface bus_arb_if;
  // master 0 (MIPS core bridge side)
  logic        m0_req;
  logic        m0_we;
  logic [29:0] m0_addr;
  logic [31:0] m0_wd;
  logic [3:0]  m0_be;
  logic [31:0] m0_rd;
  logic        m0_ack;
  // master 1 (DMA / debug loader)
  logic        m1_req;
  logic        m1_we;
  logic [29:0] m1_addr;
  logic [31:0] m1_wd;
  logic [3:0]  m1_be;
  logic [31:0] m1_rd;
  logic        m1_ack;
  // device port
  logic        dev_en;
  logic        dev_we;
  logic [29:0] dev_addr;
  logic [31:0] dev_wd;
  logic [3:0]  dev_be;
  logic [31:0] dev_rd;
  // id of the current or last granted master
  logic        gnt;

  // arbiter view
  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wd, m0_be,
    input  m1_req, m1_we, m1_addr, m1_wd, m1_be,
    input  dev_rd,
    output m0_rd, m0_ack, m1_rd, m1_ack,
    output dev_en, dev_we, dev_addr, dev_wd, dev_be, gnt
  );

  // requester / device-model view
  modport master (
    output m0_req, m0_we, m0_addr, m0_wd, m0_be,
    output m1_req, m1_we, m1_addr, m1_wd, m1_be,
    output dev_rd,
    input  m0_rd, m0_ack, m1_rd, m1_ack,
    input  dev_en, dev_we, dev_addr, dev_wd, dev_be, gnt
  );
endinterface

// File: rtl/bus_arb.sv
// Two-master bus arbiter/sequencer; ARB_RR_EN selects round-robin, else fixed priority to master 0.
// Latency: grant at sampling edge N, dev_en cycles N+1..N+WAIT_CYC, ack in cycle N+WAIT_CYC+1.
// Backpressure: requests only sampled in IDLE; one transaction per WAIT_CYC+2 cycles.
module bus_arb #(
  parameter int WAIT_CYC = 2
) (
  input logic      clk,
  input logic      rst,
  bus_arb_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_t;

  // counter value that marks the first access cycle; zero means a one-cycle access
  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYC - 1);

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        we_q;
  logic        gnt_q;
  logic        dev_en_q;
  logic        dev_we_q;
  logic [29:0] dev_addr_q;
  logic [31:0] dev_wd_q;
  logic [3:0]  dev_be_q;
  logic [31:0] m0_rd_q;
  logic [31:0] m1_rd_q;
  logic        m0_ack_q;
  logic        m1_ack_q;

  logic        any_req;
  logic        win_m1;
  logic        sel_we;
  logic [29:0] sel_addr;
  logic [31:0] sel_wd;
  logic [3:0]  sel_be;

  assign any_req = bus.m0_req | bus.m1_req;

`ifdef ARB_RR_EN
  // round-robin: on a tie the master that was not granted last wins
  always_comb begin
    win_m1 = bus.m1_req;
    if (bus.m0_req && bus.m1_req) begin
      win_m1 = ~gnt_q;
    end
  end
`else
  // fixed priority: master 0 wins whenever it requests, master 1 may starve
  always_comb begin
    win_m1 = ~bus.m0_req;
  end
`endif

  // mux the winning master's request fields toward the device registers
  always_comb begin
    sel_we   = bus.m0_we;
    sel_addr = bus.m0_addr;
    sel_wd   = bus.m0_wd;
    sel_be   = bus.m0_be;
    if (win_m1) begin
      sel_we   = bus.m1_we;
      sel_addr = bus.m1_addr;
      sel_wd   = bus.m1_wd;
      sel_be   = bus.m1_be;
    end
  end

  // sequencer FSM with all outputs registered
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      we_q       <= 1'b0;
      gnt_q      <= 1'b1;   // makes master 0 the first round-robin winner
      dev_en_q   <= 1'b0;
      dev_we_q   <= 1'b0;
      dev_addr_q <= 30'd0;
      dev_wd_q   <= 32'd0;
      dev_be_q   <= 4'b0000;
      m0_rd_q    <= 32'd0;
      m1_rd_q    <= 32'd0;
      m0_ack_q   <= 1'b0;
      m1_ack_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          m0_ack_q <= 1'b0;
          m1_ack_q <= 1'b0;
          if (any_req) begin
            gnt_q      <= win_m1;
            we_q       <= sel_we;
            dev_addr_q <= sel_addr;
            dev_wd_q   <= sel_wd;
            dev_be_q   <= sel_be;
            dev_en_q   <= 1'b1;
            // with a one-cycle access the first cycle is also the write cycle
            dev_we_q   <= sel_we && (CNT_INIT == 4'd0);
            cnt_q      <= CNT_INIT;
            state_q    <= ACCESS;
          end
        end

        ACCESS: begin
          if (cnt_q == 4'd0) begin
            // last access cycle: dev_rd is valid now
            dev_en_q <= 1'b0;
            dev_we_q <= 1'b0;
            dev_be_q <= 4'b0000;
            if (!we_q) begin
              if (gnt_q) begin
                m1_rd_q <= bus.dev_rd;
              end else begin
                m0_rd_q <= bus.dev_rd;
              end
            end
            if (gnt_q) begin
              m1_ack_q <= 1'b1;
            end else begin
              m0_ack_q <= 1'b1;
            end
            state_q <= ACK;
          end else begin
            cnt_q    <= cnt_q - 4'd1;
            // write strobe only in the cycle where the counter will read zero
            dev_we_q <= we_q && (cnt_q == 4'd1);
          end
        end

        ACK: begin
          m0_ack_q <= 1'b0;
          m1_ack_q <= 1'b0;
          state_q  <= IDLE;
        end

        default: begin
          m0_ack_q <= 1'b0;
          m1_ack_q <= 1'b0;
          dev_en_q <= 1'b0;
          dev_we_q <= 1'b0;
          dev_be_q <= 4'b0000;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign bus.dev_en   = dev_en_q;
  assign bus.dev_we   = dev_we_q;
  assign bus.dev_addr = dev_addr_q;
  assign bus.dev_wd   = dev_wd_q;
  assign bus.dev_be   = dev_be_q;
  assign bus.m0_rd    = m0_rd_q;
  assign bus.m1_rd    = m1_rd_q;
  assign bus.m0_ack   = m0_ack_q;
  assign bus.m1_ack   = m1_ack_q;
  assign bus.gnt      = gnt_q;

endmodule

// File: tb/tb_bus_arb.sv
// Bench for bus_arb: one instance with WAIT_CYC=2, one with WAIT_CYC=1.
// Latency: checks exact dev_en/ack cycles relative to the sampling edge.
// Backpressure: requests held until ack, dropped during the ack cycle.
module tb_bus_arb;

  logic clk;
  logic rst;

  bus_arb_if b2 ();
  bus_arb_if b1 ();

  bus_arb #(.WAIT_CYC(2)) u_dut2 (.clk(clk), .rst(rst), .bus(b2.slave));
  bus_arb #(.WAIT_CYC(1)) u_dut1 (.clk(clk), .rst(rst), .bus(b1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        m;
    logic [31:0] rd;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   pass_cnt;
  int   total_cnt;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    b2.m0_req = 1'b1; b2.m0_we = 1'b0; b2.m0_addr = 30'h0000010; b2.m0_wd = 32'd0; b2.m0_be = 4'hF;
    b2.m1_req = 1'b1; b2.m1_we = 1'b0; b2.m1_addr = 30'h0000020; b2.m1_wd = 32'd0; b2.m1_be = 4'hF;
    b2.dev_rd = 32'h01234567;
    b1.m0_req = 1'b0; b1.m0_we = 1'b0; b1.m0_addr = 30'h0000040; b1.m0_wd = 32'd0; b1.m0_be = 4'hF;
    b1.m1_req = 1'b0; b1.m1_we = 1'b0; b1.m1_addr = 30'd0; b1.m1_wd = 32'd0; b1.m1_be = 4'h0;
    b1.dev_rd = 32'd0;
    step(); step(); step();
    total_cnt++; if ({b2.m0_ack, b2.m1_ack} !== 2'b00) $display("FAIL rst_ack: got %b want 00", {b2.m0_ack, b2.m1_ack}); else pass_cnt++;
    total_cnt++; if ({b2.dev_en, b2.dev_we} !== 2'b00) $display("FAIL rst_dev: got %b want 00", {b2.dev_en, b2.dev_we}); else pass_cnt++;
    total_cnt++; if (b2.gnt !== 1'b1) $display("FAIL rst_gnt: got %b want 1", b2.gnt); else pass_cnt++;
    total_cnt++; if ({b2.m0_rd, b2.m1_rd} !== 64'd0) $display("FAIL rst_rd: got %h want 0", {b2.m0_rd, b2.m1_rd}); else pass_cnt++;
    total_cnt++; if ({b2.dev_addr, b2.dev_wd, b2.dev_be} !== 66'd0) $display("FAIL rst_devregs: got %h want 0", {b2.dev_addr, b2.dev_wd, b2.dev_be}); else pass_cnt++;
    // release with both requesting: master 0 must win the first edge
    rst = 1'b1;
    sb.push_back({1'b0, 32'h01234567});
    step();
    total_cnt++; if (b2.gnt !== 1'b0) $display("FAIL rst_first_gnt: got %b want 0", b2.gnt); else pass_cnt++;
    total_cnt++; if (b2.dev_addr !== 30'h0000010) $display("FAIL rst_first_addr: got %h want 10", b2.dev_addr); else pass_cnt++;
    b2.m1_req = 1'b0;
    step(); step();
    total_cnt++; if (b2.m0_ack !== 1'b1) $display("FAIL rst_first_ack: got %b want 1", b2.m0_ack); else pass_cnt++;
    if (b2.m0_ack === 1'b1 && sb.size() > 0) begin
      e = sb.pop_front();
      total_cnt++; if (b2.m0_rd !== e.rd) $display("FAIL rst_first_rd: got %h want %h", b2.m0_rd, e.rd); else pass_cnt++;
    end
    b2.m0_req = 1'b0;
    step();
  endtask

  task automatic test_m0_read;
    b2.m0_req = 1'b1; b2.m0_we = 1'b0; b2.m0_addr = 30'h1FC0; b2.m0_be = 4'hF;
    b2.dev_rd = 32'hDEADBEEF;
    sb.push_back({1'b0, 32'hDEADBEEF});
    step();
    total_cnt++; if (b2.dev_en !== 1'b1) $display("FAIL rd_en_c1: got %b want 1", b2.dev_en); else pass_cnt++;
    total_cnt++; if (b2.dev_addr !== 30'h1FC0) $display("FAIL rd_addr: got %h want 1fc0", b2.dev_addr); else pass_cnt++;
    total_cnt++; if (b2.m0_ack !== 1'b0) $display("FAIL rd_ack_c1: got %b want 0", b2.m0_ack); else pass_cnt++;
    step();
    total_cnt++; if ({b2.dev_en, b2.dev_we} !== 2'b10) $display("FAIL rd_en_c2: got %b want 10", {b2.dev_en, b2.dev_we}); else pass_cnt++;
    step();
    total_cnt++; if ({b2.m0_ack, b2.m1_ack, b2.dev_en} !== 3'b100) $display("FAIL rd_ack_c3: got %b want 100", {b2.m0_ack, b2.m1_ack, b2.dev_en}); else pass_cnt++;
    if (b2.m0_ack === 1'b1 && sb.size() > 0) begin
      e = sb.pop_front();
      total_cnt++; if (b2.m0_rd !== e.rd) $display("FAIL rd_data: got %h want %h", b2.m0_rd, e.rd); else pass_cnt++;
    end
    total_cnt++; if (b2.m1_rd !== 32'd0) $display("FAIL rd_m1_untouched: got %h want 0", b2.m1_rd); else pass_cnt++;
    b2.m0_req = 1'b0;
    step();
    total_cnt++; if (b2.m0_ack !== 1'b0) $display("FAIL rd_ack_c4: got %b want 0", b2.m0_ack); else pass_cnt++;
  endtask

  task automatic test_m1_write;
    b2.m1_req = 1'b1; b2.m1_we = 1'b1; b2.m1_addr = 30'h0ABC; b2.m1_wd = 32'h12345678; b2.m1_be = 4'b0011;
    b2.dev_rd = 32'hCAFEF00D;
    sb.push_back({1'b1, 32'd0});
    step();
    total_cnt++; if ({b2.dev_en, b2.dev_we, b2.gnt} !== 3'b101) $display("FAIL wr_c1: got %b want 101", {b2.dev_en, b2.dev_we, b2.gnt}); else pass_cnt++;
    total_cnt++; if ({b2.dev_wd, b2.dev_be} !== {32'h12345678, 4'b0011}) $display("FAIL wr_data: got %h want 123456783", {b2.dev_wd, b2.dev_be}); else pass_cnt++;
    step();
    total_cnt++; if ({b2.dev_en, b2.dev_we} !== 2'b11) $display("FAIL wr_strobe: got %b want 11", {b2.dev_en, b2.dev_we}); else pass_cnt++;
    step();
    total_cnt++; if ({b2.dev_we, b2.m1_ack, b2.m0_ack} !== 3'b010) $display("FAIL wr_ack: got %b want 010", {b2.dev_we, b2.m1_ack, b2.m0_ack}); else pass_cnt++;
    if (b2.m1_ack === 1'b1 && sb.size() > 0) begin
      e = sb.pop_front();
      total_cnt++; if (b2.m1_rd !== e.rd) $display("FAIL wr_rd_unchanged: got %h want %h", b2.m1_rd, e.rd); else pass_cnt++;
    end
    total_cnt++; if (b2.m0_rd !== 32'hDEADBEEF) $display("FAIL wr_m0_rd_held: got %h want deadbeef", b2.m0_rd); else pass_cnt++;
    b2.m1_req = 1'b0; b2.m1_we = 1'b0;
    step();
    total_cnt++; if ({b2.m1_ack, b2.dev_be} !== 5'b0) $display("FAIL wr_after: got %b want 00000", {b2.m1_ack, b2.dev_be}); else pass_cnt++;
  endtask

  task automatic test_arbitration;
    int n;
    int last;
    n = 0;
    last = 0;
    b2.m0_req = 1'b1; b2.m0_we = 1'b0;
    b2.m1_req = 1'b1; b2.m1_we = 1'b0;
    b2.dev_rd = 32'h5555AAAA;
`ifdef ARB_RR_EN
    sb.push_back({1'b0, 32'h5555AAAA});
    sb.push_back({1'b1, 32'h5555AAAA});
    sb.push_back({1'b0, 32'h5555AAAA});
    sb.push_back({1'b1, 32'h5555AAAA});
`else
    for (int k = 0; k < 4; k++) sb.push_back({1'b0, 32'h5555AAAA});
`endif
    for (int cyc = 1; cyc <= 30; cyc++) begin
      step();
      if (b2.m0_ack === 1'b1 || b2.m1_ack === 1'b1) begin
        total_cnt++; if ((b2.m0_ack & b2.m1_ack) !== 1'b0) $display("FAIL arb_dual_ack: got 11 want one-hot"); else pass_cnt++;
        if (sb.size() > 0) begin
          e = sb.pop_front();
          total_cnt++; if (b2.m1_ack !== e.m) $display("FAIL arb_order%0d: got master %b want %b", n, b2.m1_ack, e.m); else pass_cnt++;
          total_cnt++; if ((e.m ? b2.m1_rd : b2.m0_rd) !== e.rd) $display("FAIL arb_rd%0d: got %h want %h", n, (e.m ? b2.m1_rd : b2.m0_rd), e.rd); else pass_cnt++;
        end
        if (n > 0) begin
          total_cnt++; if (cyc - last !== 4) $display("FAIL arb_spacing%0d: got %0d want 4", n, cyc - last); else pass_cnt++;
        end
        last = cyc;
        n++;
        if (n == 4) begin
          b2.m0_req = 1'b0;
          b2.m1_req = 1'b0;
          break;
        end
      end
    end
    total_cnt++; if (n !== 4) $display("FAIL arb_timeout: got %0d acks want 4", n); else pass_cnt++;
    b2.m0_req = 1'b0;
    b2.m1_req = 1'b0;
    step(); step();
    total_cnt++; if (b2.dev_en !== 1'b0) $display("FAIL arb_idle: got %b want 0", b2.dev_en); else pass_cnt++;
  endtask

  task automatic test_reset_mid_access;
    b2.m0_req = 1'b1; b2.m0_we = 1'b0; b2.m0_addr = 30'h0123;
    b2.dev_rd = 32'h0BADF00D;
    step();
    total_cnt++; if (b2.dev_en !== 1'b1) $display("FAIL mrst_en_c1: got %b want 1", b2.dev_en); else pass_cnt++;
    step();
    rst = 1'b0;
    #1;
    total_cnt++; if ({b2.dev_en, b2.m0_ack, b2.gnt} !== 3'b001) $display("FAIL mrst_clear: got %b want 001", {b2.dev_en, b2.m0_ack, b2.gnt}); else pass_cnt++;
    total_cnt++; if (b2.m0_rd !== 32'd0) $display("FAIL mrst_rd: got %h want 0", b2.m0_rd); else pass_cnt++;
    step();
    total_cnt++; if ({b2.dev_en, b2.m0_ack} !== 2'b00) $display("FAIL mrst_noack: got %b want 00", {b2.dev_en, b2.m0_ack}); else pass_cnt++;
    rst = 1'b1;
    sb.push_back({1'b0, 32'h0BADF00D});
    step();
    total_cnt++; if ({b2.dev_en, b2.gnt} !== 2'b10) $display("FAIL mrst_regrant: got %b want 10", {b2.dev_en, b2.gnt}); else pass_cnt++;
    step(); step();
    total_cnt++; if (b2.m0_ack !== 1'b1) $display("FAIL mrst_ack: got %b want 1", b2.m0_ack); else pass_cnt++;
    if (b2.m0_ack === 1'b1 && sb.size() > 0) begin
      e = sb.pop_front();
      total_cnt++; if (b2.m0_rd !== e.rd) $display("FAIL mrst_data: got %h want %h", b2.m0_rd, e.rd); else pass_cnt++;
    end
    b2.m0_req = 1'b0;
    step();
  endtask

  task automatic test_back_to_back;
    logic exp_ack;
    logic exp_en;
    b1.m0_req = 1'b1; b1.m0_we = 1'b0;
    b1.dev_rd = 32'hA5A50000;
    for (int c = 1; c <= 9; c++) begin
      step();
      exp_ack = (c == 2 || c == 5 || c == 8);
      exp_en  = (c == 1 || c == 4 || c == 7);
      total_cnt++; if (b1.m0_ack !== exp_ack) $display("FAIL b2b_ack_c%0d: got %b want %b", c, b1.m0_ack, exp_ack); else pass_cnt++;
      total_cnt++; if (b1.dev_en !== exp_en) $display("FAIL b2b_en_c%0d: got %b want %b", c, b1.dev_en, exp_en); else pass_cnt++;
      if (b1.m0_ack === 1'b1 && sb.size() > 0) begin
        e = sb.pop_front();
        total_cnt++; if (b1.m0_rd !== e.rd) $display("FAIL b2b_rd_c%0d: got %h want %h", c, b1.m0_rd, e.rd); else pass_cnt++;
      end
      // value driven in an access cycle is captured at the closing edge
      b1.dev_rd = 32'hA5A50000 + 32'(c);
      if (exp_en) sb.push_back({1'b0, 32'hA5A50000 + 32'(c)});
      if (c == 8) b1.m0_req = 1'b0;
    end
    total_cnt++; if (sb.size() !== 0) $display("FAIL sb_leftover: got %0d entries want 0", sb.size()); else pass_cnt++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    test_reset();
    test_m0_read();
    test_m1_write();
    test_arbitration();
    test_reset_mid_access();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
